// File: rtl/nave_pkg.sv
// Shared definitions for the ship/hazard logic: default ship size, hit limit,
// screen limits, FSM state type and the hazard box record.
package nave_pkg;

    localparam int NAVE_LARG_PAD = 45;
    localparam int NAVE_ALT_PAD  = 51;
    localparam int MAX_BATIDAS   = 3;
    localparam int TELA_LARG     = 640;
    localparam int TELA_ALT      = 480;

    typedef logic [1:0] estado_t;
    localparam estado_t ATIVO = 2'd0;
    localparam estado_t INVUL = 2'd1;
    localparam estado_t FIM   = 2'd2;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] w;
        logic [7:0] h;
    } caixa_t;

    // a < b + bw, with the sum one bit wider so it never wraps
    function automatic logic antes(input logic [9:0] a, input logic [9:0] b,
                                   input logic [7:0] bw);
        return {1'b0, a} < ({1'b0, b} + {3'b000, bw});
    endfunction

endpackage

// File: rtl/sobreposicao_aabb.sv
// Combinational strict axis-aligned box overlap; touching edges do not count.
module sobreposicao_aabb
    import nave_pkg::*;
(
    input  logic   valido,
    input  caixa_t a,
    input  caixa_t b,
    output logic   sobre
);

    logic sobre_x;
    logic sobre_y;

    assign sobre_x = antes(b.x, a.x, a.w) && antes(a.x, b.x, b.w);
    assign sobre_y = antes(b.y, a.y, a.h) && antes(a.y, b.y, b.h);
    assign sobre   = valido && sobre_x && sobre_y;

endmodule

// File: rtl/contador_batidas.sv
// Ship hit counter: registered overlap, ATIVO/INVUL/FIM FSM, saturating at 3.
// Optional sprite blinking during invulnerability with NAVE_PISCA_EN.
module contador_batidas
    import nave_pkg::*;
#(
    parameter int NAVE_LARG     = NAVE_LARG_PAD,
    parameter int NAVE_ALT      = NAVE_ALT_PAD,
    parameter int INVUL_QUADROS = 60
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       reiniciarJogo,
    input  logic       pausa,
    input  logic       quadro_tick,
    input  logic [9:0] x_nave,
    input  logic [9:0] y_nave,
    input  logic       obj_valid,
    input  logic [9:0] obj_x,
    input  logic [9:0] obj_y,
    input  logic [7:0] obj_w,
    input  logic [7:0] obj_h,
    output logic [1:0] n_batidas,
    output logic       batida_pulso,
    output logic       invulneravel,
    output logic       nave_visivel
);

    localparam logic [1:0] ULTIMA = 2'(MAX_BATIDAS - 1);

    caixa_t  nave;
    caixa_t  obj;
    logic    sobre;
    logic    sobre_q;
    logic    limpa;
    logic    conta_batida;
    logic    tick_ok;
    logic    fim_invul;
    estado_t estado;
    logic [7:0] contador;

    assign limpa = reset || reiniciarJogo;
    assign nave  = '{x: x_nave, y: y_nave, w: 8'(NAVE_LARG), h: 8'(NAVE_ALT)};
    assign obj   = '{x: obj_x, y: obj_y, w: obj_w, h: obj_h};

    sobreposicao_aabb u_aabb (
        .valido (obj_valid),
        .a      (nave),
        .b      (obj),
        .sobre  (sobre)
    );

    always_ff @(posedge CLOCK_50) begin
        if (limpa) sobre_q <= 1'b0;
        else       sobre_q <= sobre;
    end

    // Only ATIVO listens to stage 1, so overlaps queued behind a hit die here
    assign conta_batida = (estado == ATIVO) && sobre_q && !pausa;
    assign tick_ok      = (estado == INVUL) && quadro_tick && !pausa;
    assign fim_invul    = tick_ok && (contador == 8'd1);

    always_ff @(posedge CLOCK_50) begin
        if (limpa) begin
            estado       <= ATIVO;
            n_batidas    <= 2'd0;
            batida_pulso <= 1'b0;
            contador     <= 8'd0;
        end else begin
            batida_pulso <= 1'b0;
            case (estado)
                ATIVO: begin
                    if (conta_batida) begin
                        n_batidas    <= n_batidas + 2'd1;
                        batida_pulso <= 1'b1;
                        if (n_batidas == ULTIMA) begin
                            estado <= FIM;
                        end else begin
                            estado   <= INVUL;
                            contador <= 8'(INVUL_QUADROS);
                        end
                    end
                end
                INVUL: begin
                    if (tick_ok) begin
                        contador <= contador - 8'd1;
                        if (fim_invul) estado <= ATIVO;
                    end
                end
                FIM: n_batidas <= 2'(MAX_BATIDAS);
                default: estado <= ATIVO;
            endcase
        end
    end

    assign invulneravel = (estado == INVUL);

`ifdef NAVE_PISCA_EN
    logic [1:0] fase;
    logic       visivel_q;

    always_ff @(posedge CLOCK_50) begin
        if (limpa) begin
            fase      <= 2'd0;
            visivel_q <= 1'b1;
        end else if (conta_batida && (n_batidas != ULTIMA)) begin
            fase      <= 2'd0;
            visivel_q <= 1'b0;
        end else if (tick_ok) begin
            if (fim_invul) begin
                fase      <= 2'd0;
                visivel_q <= 1'b1;
            end else begin
                fase <= fase + 2'd1;
                if (fase == 2'd3) visivel_q <= ~visivel_q;
            end
        end
    end

    assign nave_visivel = visivel_q;
`else
    assign nave_visivel = 1'b1;
`endif

endmodule

// File: tb/tb_contador_batidas.sv
// Scoreboard bench for contador_batidas: directed scenarios then random traffic.
module tb_contador_batidas;

    localparam int NL = 45;
    localparam int NA = 51;
    localparam int IQ = 60;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b0, reiniciarJogo = 1'b0, pausa = 1'b0, quadro_tick = 1'b0;
    logic [9:0] x_nave = '0, y_nave = '0, obj_x = '0, obj_y = '0;
    logic       obj_valid = 1'b0;
    logic [7:0] obj_w = '0, obj_h = '0;
    logic [1:0] n_batidas;
    logic       batida_pulso, invulneravel, nave_visivel;

    contador_batidas #(.NAVE_LARG(NL), .NAVE_ALT(NA), .INVUL_QUADROS(IQ)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .reiniciarJogo(reiniciarJogo),
        .pausa(pausa), .quadro_tick(quadro_tick), .x_nave(x_nave), .y_nave(y_nave),
        .obj_valid(obj_valid), .obj_x(obj_x), .obj_y(obj_y), .obj_w(obj_w),
        .obj_h(obj_h), .n_batidas(n_batidas), .batida_pulso(batida_pulso),
        .invulneravel(invulneravel), .nave_visivel(nave_visivel)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int n;
        bit p;
        bit i;
        bit v;
    } esperado_t;

    esperado_t q[$];
    int  checks = 0, errors = 0;
    bit  started = 0, done = 0;

    // Reference: hits taken, frames of invulnerability left, blink phase
    int m_hits = 0, m_left = 0, m_ticks = 0;
    bit m_vis = 1, m_pend = 0;
    int sx = 320, sy = 410;

    function automatic bit toca(int ox, int oy, int ow, int oh, int nx, int ny);
        return (ox < nx + NL) && (nx < ox + ow) && (oy < ny + NA) && (ny < oy + oh);
    endfunction

    task automatic passo(input bit rst, input bit rein, input bit pau, input bit tick,
                         input bit val, input int ox, input int oy, input int ow, input int oh);
        esperado_t e;
        bit pulso;
        @(negedge CLOCK_50);
        reset = rst; reiniciarJogo = rein; pausa = pau; quadro_tick = tick;
        obj_valid = val; obj_x = 10'(ox); obj_y = 10'(oy); obj_w = 8'(ow); obj_h = 8'(oh);
        x_nave = 10'(sx); y_nave = 10'(sy);
        pulso = 0;
        if (rst || rein) begin
            m_hits = 0; m_left = 0; m_vis = 1; m_pend = 0; m_ticks = 0;
        end else begin
            if (m_left == 0 && m_hits < 3 && m_pend && !pau) begin
                m_hits++;
                pulso = 1;
                if (m_hits < 3) begin
                    m_left = IQ; m_ticks = 0;
`ifdef NAVE_PISCA_EN
                    m_vis = 0;
`endif
                end
            end else if (m_left > 0 && tick && !pau) begin
                m_left--;
                m_ticks++;
`ifdef NAVE_PISCA_EN
                if (m_ticks % 4 == 0) m_vis = !m_vis;
`endif
                if (m_left == 0) m_vis = 1;
            end
            m_pend = val && toca(ox, oy, ow, oh, sx, sy);
        end
        e.n = m_hits; e.p = pulso; e.i = (m_left > 0); e.v = m_vis;
        q.push_back(e);
        started = 1;
    endtask

    task automatic ocioso(input int n);
        for (int k = 0; k < n; k++)
            passo(0, 0, 0, 0, 0, $urandom_range(0, 1023), $urandom_range(0, 1023),
                  $urandom_range(0, 255), $urandom_range(0, 255));
    endtask

    task automatic ticks(input int n, input bit pau, input bit acerto);
        for (int k = 0; k < n; k++) begin
            passo(0, 0, pau, 1, acerto, sx + 20, sy + 10, 16, 16);
            passo(0, 0, pau, 0, 0, 0, 0, 0, 0);
        end
    endtask

    // Monitor: one expected record per clock edge, compared just after the edge
    initial begin : monitor
        esperado_t e;
        int vazio = 0;
        forever begin
            @(posedge CLOCK_50);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (n_batidas !== 2'(e.n) || batida_pulso !== e.p ||
                    invulneravel !== e.i || nave_visivel !== e.v) begin
                    errors++;
                    $display("FAIL saida @%0t: got n=%0d pulso=%b inv=%b vis=%b, want n=%0d pulso=%b inv=%b vis=%b",
                             $time, n_batidas, batida_pulso, invulneravel, nave_visivel,
                             e.n, e.p, e.i, e.v);
                end
            end else if (done) begin
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end else if (started) begin
                vazio++;
                if (vazio > 50) begin
                    errors++;
                    $display("FAIL timeout: got empty queue for %0d cycles, want a record each cycle", vazio);
                    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                    $finish;
                end
            end
        end
    end

    initial begin : estimulo
        int ox, oy;
        passo(1, 0, 0, 0, 0, 0, 0, 0, 0);
        passo(1, 0, 0, 0, 1, 320, 410, 50, 50);
        sx = 320; sy = 410;
        passo(0, 0, 0, 0, 1, 340, 420, 16, 16);
        ocioso(4);
        ticks(IQ, 0, 0);
        ocioso(2);
        passo(0, 0, 0, 0, 1, 365, 410, 16, 16);
        ocioso(4);
        for (int k = 0; k < 5; k++) passo(0, 0, 0, 0, 1, 330 + k, 415, 16, 16);
        ocioso(3);
        ticks(IQ, 0, 1);
        ocioso(2);
        passo(0, 0, 0, 0, 1, 300, 400, 30, 30);
        ocioso(3);
        ticks(200, 0, 1);
        passo(0, 0, 0, 0, 1, 340, 420, 16, 16);
        passo(0, 1, 0, 0, 1, 340, 420, 16, 16);
        ocioso(3);
        passo(0, 0, 0, 0, 1, 340, 420, 16, 16);
        ocioso(3);
        ticks(IQ - 30, 0, 0);
        ticks(50, 1, 1);
        ticks(30, 0, 0);
        ocioso(3);
        for (int c = 0; c < 4000; c++) begin
            if (c % 300 == 0) begin
                sx = $urandom_range(0, 595);
                sy = $urandom_range(0, 429);
            end
            ox = sx - 40 + int'($urandom_range(0, 100));
            oy = sy - 40 + int'($urandom_range(0, 110));
            if (ox < 0) ox = 0;
            if (oy < 0) oy = 0;
            passo($urandom_range(0, 899) == 0, $urandom_range(0, 699) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0, ox, oy,
                  $urandom_range(1, 40), $urandom_range(1, 40));
        end
        done = 1;
    end

endmodule
